// File: rtl/id_hazard_forward_unit.sv
// ID-stage hazard/forwarding controller: load-use and branch-in-ID RAW stall sequencing,
// ID operand bypass from MEM/WB, and registered EX forward selects for the ID/EXE register.
module id_hazard_forward_unit #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned REG_ADDR_W   = 5,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned BRANCH_IN_ID = 1
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  Valid_IN,
  input  logic [REG_ADDR_W-1:0] RegisterRS_IN,
  input  logic [REG_ADDR_W-1:0] RegisterRT_IN,
  input  logic                  UsesRS_IN,
  input  logic                  UsesRT_IN,
  input  logic                  IsBranch_IN,
  input  logic                  Flush_IN,
  input  logic [DATA_W-1:0]     RSValue_IN,
  input  logic [DATA_W-1:0]     RTValue_IN,
  input  logic [REG_ADDR_W-1:0] EXEWriteRegister_IN,
  input  logic                  EXEWriteEnable_IN,
  input  logic                  EXEMemRead_IN,
  input  logic [REG_ADDR_W-1:0] MEMWriteRegister_IN,
  input  logic                  MEMWriteEnable_IN,
  input  logic                  MEMMemRead_IN,
  input  logic [DATA_W-1:0]     MEMValue_IN,
  input  logic [REG_ADDR_W-1:0] WBWriteRegister_IN,
  input  logic                  WBWriteEnable_IN,
  input  logic [DATA_W-1:0]     WBValue_IN,
  output logic                  Stall_OUT,
  output logic                  Bubble_OUT,
  output logic [DATA_W-1:0]     OperandRS_OUT,
  output logic [DATA_W-1:0]     OperandRT_OUT,
  output logic [1:0]            FwdA_OUT,
  output logic [1:0]            FwdB_OUT,
  output logic                  IDEXValid_OUT,
  output logic [CNT_W-1:0]      StallCycles_OUT,
  output logic [CNT_W-1:0]      LoadUseEvents_OUT
);

  typedef enum logic {RUN, STALL} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t     state, state_n;
  logic [1:0] cnt, cnt_n;
  logic       exe_rs, exe_rt, mem_rs, mem_rt;
  logic       branch_id, load_use, advance;
  logic [1:0] need_rs, need_rt, need;

  function automatic logic [1:0] need_of(input logic exe_m, input logic mem_m,
                                         input logic exe_load, input logic mem_load,
                                         input logic br);
    logic [1:0] n;
    n = '0;
    if (exe_m && exe_load)
      n = br ? 2'd2 : 2'd1;
    else if (br && (exe_m || (mem_m && mem_load)))
      n = 2'd1;
    return n;
  endfunction

  function automatic logic [1:0] fwd_of(input logic exe_m, input logic mem_m, input logic exe_load);
    logic [1:0] f;
    f = 2'b00;
    if (exe_m && !exe_load)
      f = 2'b10;
    else if (exe_m || mem_m)
      f = 2'b01;
    return f;
  endfunction

  function automatic logic [DATA_W-1:0] operand_of(
    input logic [REG_ADDR_W-1:0] r,        input logic [DATA_W-1:0] rf,
    input logic                  mem_we,   input logic [REG_ADDR_W-1:0] mem_reg,
    input logic                  mem_load, input logic [DATA_W-1:0] mem_val,
    input logic                  wb_we,    input logic [REG_ADDR_W-1:0] wb_reg,
    input logic [DATA_W-1:0]     wb_val);
    logic [DATA_W-1:0] v;
    v = rf;
    if (r == '0)
      v = '0;
    else if (mem_we && !mem_load && (mem_reg == r))
      v = mem_val;
    else if (wb_we && (wb_reg == r))
      v = wb_val;
    return v;
  endfunction

  assign exe_rs = UsesRS_IN && EXEWriteEnable_IN && (RegisterRS_IN != '0) && (RegisterRS_IN == EXEWriteRegister_IN);
  assign exe_rt = UsesRT_IN && EXEWriteEnable_IN && (RegisterRT_IN != '0) && (RegisterRT_IN == EXEWriteRegister_IN);
  assign mem_rs = UsesRS_IN && MEMWriteEnable_IN && (RegisterRS_IN != '0) && (RegisterRS_IN == MEMWriteRegister_IN);
  assign mem_rt = UsesRT_IN && MEMWriteEnable_IN && (RegisterRT_IN != '0) && (RegisterRT_IN == MEMWriteRegister_IN);

  assign branch_id = (BRANCH_IN_ID != 0) && IsBranch_IN;
  assign need_rs   = need_of(exe_rs, mem_rs, EXEMemRead_IN, MEMMemRead_IN, branch_id);
  assign need_rt   = need_of(exe_rt, mem_rt, EXEMemRead_IN, MEMMemRead_IN, branch_id);
  assign need      = !Valid_IN ? 2'd0 : ((need_rs > need_rt) ? need_rs : need_rt);
  assign load_use  = Valid_IN && EXEMemRead_IN && (exe_rs || exe_rt);

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // The entry cycle in RUN is itself the first stall; cnt counts the STALL-state cycles still owed.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (Flush_IN) begin
      state_n = RUN;
      cnt_n   = '0;
    end else begin
      case (state)
        RUN: begin
          if (need != 2'd0) begin
            cnt_n   = need - 2'd1;
            state_n = (need > 2'd1) ? STALL : RUN;
          end
        end
        STALL: begin
          cnt_n = cnt - 2'd1;
          if (cnt <= 2'd1) state_n = RUN;
        end
        default: begin
          state_n = RUN;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_comb begin
    Stall_OUT  = 1'b0;
    Bubble_OUT = 1'b0;
    if (Flush_IN) begin
      Bubble_OUT = 1'b1;
    end else if (state == STALL || need != 2'd0) begin
      Stall_OUT  = 1'b1;
      Bubble_OUT = 1'b1;
    end
  end

  assign OperandRS_OUT = operand_of(RegisterRS_IN, RSValue_IN, MEMWriteEnable_IN, MEMWriteRegister_IN,
                                    MEMMemRead_IN, MEMValue_IN, WBWriteEnable_IN, WBWriteRegister_IN, WBValue_IN);
  assign OperandRT_OUT = operand_of(RegisterRT_IN, RTValue_IN, MEMWriteEnable_IN, MEMWriteRegister_IN,
                                    MEMMemRead_IN, MEMValue_IN, WBWriteEnable_IN, WBWriteRegister_IN, WBValue_IN);

  assign advance = Valid_IN && !Stall_OUT && !Flush_IN;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      IDEXValid_OUT     <= 1'b0;
      FwdA_OUT          <= 2'b00;
      FwdB_OUT          <= 2'b00;
      StallCycles_OUT   <= '0;
      LoadUseEvents_OUT <= '0;
    end else begin
      if (advance) begin
        IDEXValid_OUT <= 1'b1;
        FwdA_OUT      <= fwd_of(exe_rs, mem_rs, EXEMemRead_IN);
        FwdB_OUT      <= fwd_of(exe_rt, mem_rt, EXEMemRead_IN);
      end else begin
        IDEXValid_OUT <= 1'b0;
        FwdA_OUT      <= 2'b00;
        FwdB_OUT      <= 2'b00;
      end
      if (Stall_OUT && StallCycles_OUT != '1)
        StallCycles_OUT <= StallCycles_OUT + CNT_ONE;
      if (!Flush_IN && state == RUN && load_use && LoadUseEvents_OUT != '1)
        LoadUseEvents_OUT <= LoadUseEvents_OUT + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_id_hazard_forward_unit.sv
// Directed-vector bench for id_hazard_forward_unit with hand-computed expectations.
module tb_id_hazard_forward_unit;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        Valid_IN;
  logic [4:0]  RegisterRS_IN, RegisterRT_IN;
  logic        UsesRS_IN, UsesRT_IN, IsBranch_IN, Flush_IN;
  logic [31:0] RSValue_IN, RTValue_IN;
  logic [4:0]  EXEWriteRegister_IN;
  logic        EXEWriteEnable_IN, EXEMemRead_IN;
  logic [4:0]  MEMWriteRegister_IN;
  logic        MEMWriteEnable_IN, MEMMemRead_IN;
  logic [31:0] MEMValue_IN;
  logic [4:0]  WBWriteRegister_IN;
  logic        WBWriteEnable_IN;
  logic [31:0] WBValue_IN;
  logic        Stall_OUT, Bubble_OUT;
  logic [31:0] OperandRS_OUT, OperandRT_OUT;
  logic [1:0]  FwdA_OUT, FwdB_OUT;
  logic        IDEXValid_OUT;
  logic [15:0] StallCycles_OUT, LoadUseEvents_OUT;

  int unsigned checks = 0;
  int unsigned errors = 0;

  id_hazard_forward_unit #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(16), .BRANCH_IN_ID(1)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .Valid_IN(Valid_IN),
    .RegisterRS_IN(RegisterRS_IN), .RegisterRT_IN(RegisterRT_IN),
    .UsesRS_IN(UsesRS_IN), .UsesRT_IN(UsesRT_IN), .IsBranch_IN(IsBranch_IN), .Flush_IN(Flush_IN),
    .RSValue_IN(RSValue_IN), .RTValue_IN(RTValue_IN),
    .EXEWriteRegister_IN(EXEWriteRegister_IN), .EXEWriteEnable_IN(EXEWriteEnable_IN),
    .EXEMemRead_IN(EXEMemRead_IN),
    .MEMWriteRegister_IN(MEMWriteRegister_IN), .MEMWriteEnable_IN(MEMWriteEnable_IN),
    .MEMMemRead_IN(MEMMemRead_IN), .MEMValue_IN(MEMValue_IN),
    .WBWriteRegister_IN(WBWriteRegister_IN), .WBWriteEnable_IN(WBWriteEnable_IN),
    .WBValue_IN(WBValue_IN),
    .Stall_OUT(Stall_OUT), .Bubble_OUT(Bubble_OUT),
    .OperandRS_OUT(OperandRS_OUT), .OperandRT_OUT(OperandRT_OUT),
    .FwdA_OUT(FwdA_OUT), .FwdB_OUT(FwdB_OUT), .IDEXValid_OUT(IDEXValid_OUT),
    .StallCycles_OUT(StallCycles_OUT), .LoadUseEvents_OUT(LoadUseEvents_OUT)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    Valid_IN = 1'b0; RegisterRS_IN = '0; RegisterRT_IN = '0;
    UsesRS_IN = 1'b0; UsesRT_IN = 1'b0; IsBranch_IN = 1'b0; Flush_IN = 1'b0;
    RSValue_IN = '0; RTValue_IN = '0;
    EXEWriteRegister_IN = '0; EXEWriteEnable_IN = 1'b0; EXEMemRead_IN = 1'b0;
    MEMWriteRegister_IN = '0; MEMWriteEnable_IN = 1'b0; MEMMemRead_IN = 1'b0; MEMValue_IN = '0;
    WBWriteRegister_IN = '0; WBWriteEnable_IN = 1'b0; WBValue_IN = '0;
  endtask

  task automatic id_instr(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                          input logic urt, input logic br);
    Valid_IN = 1'b1; RegisterRS_IN = rs; RegisterRT_IN = rt;
    UsesRS_IN = urs; UsesRT_IN = urt; IsBranch_IN = br;
  endtask

  // Advance one clock; sampling happens 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  initial begin
    idle();
    RESET = 1'b1;
    #12;
    check("rst_stall", {31'd0, Stall_OUT}, 32'd0);
    check("rst_bubble", {31'd0, Bubble_OUT}, 32'd0);
    check("rst_idexv", {31'd0, IDEXValid_OUT}, 32'd0);
    check("rst_fwda", {30'd0, FwdA_OUT}, 32'd0);
    check("rst_sc", {16'd0, StallCycles_OUT}, 32'd0);
    check("rst_lu", {16'd0, LoadUseEvents_OUT}, 32'd0);
    RESET = 1'b0;
    tick();

    // lw $8 in EXE, add uses $8
    idle(); id_instr(5'd8, 5'd3, 1'b1, 1'b1, 1'b0);
    EXEWriteRegister_IN = 5'd8; EXEWriteEnable_IN = 1'b1; EXEMemRead_IN = 1'b1;
    #1;
    check("lu_stall", {31'd0, Stall_OUT}, 32'd1);
    check("lu_bubble", {31'd0, Bubble_OUT}, 32'd1);
    tick();
    check("lu_idexv0", {31'd0, IDEXValid_OUT}, 32'd0);
    check("lu_events", {16'd0, LoadUseEvents_OUT}, 32'd1);
    idle(); id_instr(5'd8, 5'd3, 1'b1, 1'b1, 1'b0);
    MEMWriteRegister_IN = 5'd8; MEMWriteEnable_IN = 1'b1; MEMMemRead_IN = 1'b1;
    #1;
    check("lu_release", {31'd0, Stall_OUT}, 32'd0);
    tick();
    check("lu_fwda", {30'd0, FwdA_OUT}, 32'd1);
    check("lu_fwdb", {30'd0, FwdB_OUT}, 32'd0);
    check("lu_idexv1", {31'd0, IDEXValid_OUT}, 32'd1);
    check("lu_sc", {16'd0, StallCycles_OUT}, 32'd1);

    // add $9 in EXE, beq $9,$10 in ID
    idle(); id_instr(5'd9, 5'd10, 1'b1, 1'b1, 1'b1);
    EXEWriteRegister_IN = 5'd9; EXEWriteEnable_IN = 1'b1;
    #1;
    check("br_stall", {31'd0, Stall_OUT}, 32'd1);
    tick();
    check("br_sc", {16'd0, StallCycles_OUT}, 32'd2);
    check("br_lu", {16'd0, LoadUseEvents_OUT}, 32'd1);
    idle(); id_instr(5'd9, 5'd10, 1'b1, 1'b1, 1'b1);
    RSValue_IN = 32'h1111; RTValue_IN = 32'h55;
    MEMWriteRegister_IN = 5'd9; MEMWriteEnable_IN = 1'b1; MEMValue_IN = 32'h1234;
    #1;
    check("br_nostall", {31'd0, Stall_OUT}, 32'd0);
    check("br_oprs_mem", OperandRS_OUT, 32'h1234);
    check("br_oprt_rf", OperandRT_OUT, 32'h55);
    tick();
    check("br_fwda", {30'd0, FwdA_OUT}, 32'd1);

    // lw $9 in EXE, beq $9: two stall cycles, the second held by the FSM alone
    idle(); id_instr(5'd9, 5'd0, 1'b1, 1'b0, 1'b1);
    EXEWriteRegister_IN = 5'd9; EXEWriteEnable_IN = 1'b1; EXEMemRead_IN = 1'b1;
    #1;
    check("lb_stall1", {31'd0, Stall_OUT}, 32'd1);
    tick();
    idle(); id_instr(5'd9, 5'd0, 1'b1, 1'b0, 1'b1);
    #1;
    check("lb_stall2", {31'd0, Stall_OUT}, 32'd1);
    check("lb_bubble2", {31'd0, Bubble_OUT}, 32'd1);
    tick();
    check("lb_sc", {16'd0, StallCycles_OUT}, 32'd4);
    check("lb_lu", {16'd0, LoadUseEvents_OUT}, 32'd2);
    idle(); id_instr(5'd9, 5'd0, 1'b1, 1'b0, 1'b1);
    RSValue_IN = 32'h1; WBWriteRegister_IN = 5'd9; WBWriteEnable_IN = 1'b1; WBValue_IN = 32'hBEEF;
    #1;
    check("lb_release", {31'd0, Stall_OUT}, 32'd0);
    check("lb_oprs_wb", OperandRS_OUT, 32'hBEEF);
    tick();
    check("lb_fwda", {30'd0, FwdA_OUT}, 32'd0);
    check("lb_idexv", {31'd0, IDEXValid_OUT}, 32'd1);

    // WB writes $5 while ID reads it; MEM takes priority unless it is a load
    idle(); id_instr(5'd5, 5'd5, 1'b1, 1'b1, 1'b0);
    RSValue_IN = 32'h1111; WBWriteRegister_IN = 5'd5; WBWriteEnable_IN = 1'b1; WBValue_IN = 32'hDEAD;
    #1;
    check("wb_nostall", {31'd0, Stall_OUT}, 32'd0);
    check("wb_oprs", OperandRS_OUT, 32'hDEAD);
    MEMWriteRegister_IN = 5'd5; MEMWriteEnable_IN = 1'b1; MEMValue_IN = 32'hAAAA;
    #1;
    check("memprio_oprs", OperandRS_OUT, 32'hAAAA);
    MEMMemRead_IN = 1'b1;
    #1;
    check("memload_oprt", OperandRT_OUT, 32'hDEAD);
    tick();
    check("memload_fwdb", {30'd0, FwdB_OUT}, 32'd1);

    // EXE non-load producer for both sources of an ALU op
    idle(); id_instr(5'd7, 5'd7, 1'b1, 1'b1, 1'b0);
    EXEWriteRegister_IN = 5'd7; EXEWriteEnable_IN = 1'b1;
    #1;
    check("ex_nostall", {31'd0, Stall_OUT}, 32'd0);
    tick();
    check("ex_fwda", {30'd0, FwdA_OUT}, 32'd2);
    check("ex_fwdb", {30'd0, FwdB_OUT}, 32'd2);

    // Flush during a two-cycle stall
    idle(); id_instr(5'd9, 5'd0, 1'b1, 1'b0, 1'b1);
    EXEWriteRegister_IN = 5'd9; EXEWriteEnable_IN = 1'b1; EXEMemRead_IN = 1'b1;
    tick();
    check("fl_sc_pre", {16'd0, StallCycles_OUT}, 32'd5);
    idle(); id_instr(5'd9, 5'd0, 1'b1, 1'b0, 1'b1); Flush_IN = 1'b1;
    #1;
    check("fl_stall", {31'd0, Stall_OUT}, 32'd0);
    check("fl_bubble", {31'd0, Bubble_OUT}, 32'd1);
    tick();
    check("fl_idexv", {31'd0, IDEXValid_OUT}, 32'd0);
    check("fl_sc", {16'd0, StallCycles_OUT}, 32'd5);
    idle(); id_instr(5'd3, 5'd0, 1'b1, 1'b0, 1'b0);
    #1;
    check("fl_run", {31'd0, Stall_OUT}, 32'd0);
    tick();
    check("fl_idexv1", {31'd0, IDEXValid_OUT}, 32'd1);

    // Register 0 never matches
    idle(); id_instr(5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
    RSValue_IN = 32'h777;
    EXEWriteRegister_IN = 5'd0; EXEWriteEnable_IN = 1'b1; EXEMemRead_IN = 1'b1;
    #1;
    check("r0_nostall", {31'd0, Stall_OUT}, 32'd0);
    check("r0_oprs", OperandRS_OUT, 32'd0);
    tick();
    check("r0_fwda", {30'd0, FwdA_OUT}, 32'd0);

    // Unused source and invalid slot do not stall
    idle(); id_instr(5'd6, 5'd0, 1'b0, 1'b0, 1'b0);
    EXEWriteRegister_IN = 5'd6; EXEWriteEnable_IN = 1'b1; EXEMemRead_IN = 1'b1;
    #1;
    check("unused_nostall", {31'd0, Stall_OUT}, 32'd0);
    UsesRS_IN = 1'b1; Valid_IN = 1'b0;
    #1;
    check("invalid_nostall", {31'd0, Stall_OUT}, 32'd0);
    tick();
    check("invalid_idexv", {31'd0, IDEXValid_OUT}, 32'd0);

    // RESET in the middle of a stall
    idle(); id_instr(5'd9, 5'd0, 1'b1, 1'b0, 1'b1);
    EXEWriteRegister_IN = 5'd9; EXEWriteEnable_IN = 1'b1; EXEMemRead_IN = 1'b1;
    tick();
    idle(); id_instr(5'd9, 5'd0, 1'b1, 1'b0, 1'b1);
    #1;
    check("mid_stall", {31'd0, Stall_OUT}, 32'd1);
    RESET = 1'b1;
    #1;
    check("mid_rst_stall", {31'd0, Stall_OUT}, 32'd0);
    check("mid_rst_sc", {16'd0, StallCycles_OUT}, 32'd0);
    check("mid_rst_lu", {16'd0, LoadUseEvents_OUT}, 32'd0);
    RESET = 1'b0;
    tick();
    check("post_rst_idexv", {31'd0, IDEXValid_OUT}, 32'd1);
    check("post_rst_sc", {16'd0, StallCycles_OUT}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
